// File: rtl/mvu_pe_acc.sv
// Accumulates per-PE partial dot products over SF synapse-fold beats and emits one sum vector per fold.
// Optional MVU_ACC_SAT_EN: saturating lane adds instead of modulo-2^TA wrap.
module mvu_pe_acc #(
    parameter int PE = 2,
    parameter int TO = 16,
    parameter int TA = 24,
    parameter int SF = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_v,
    output logic               in_rdy,
    input  logic [PE*TO-1:0]   in_data,
    output logic               out_v,
    input  logic               out_rdy,
    output logic [PE*TA-1:0]   out_data
);

    localparam int CW = (SF > 1) ? $clog2(SF) : 1;
    localparam logic [CW-1:0] LAST_CNT = CW'(SF - 1);

`ifdef MVU_ACC_SAT_EN
    localparam logic signed [TA-1:0] SMAX = {1'b0, {(TA-1){1'b1}}};
    localparam logic signed [TA-1:0] SMIN = ~SMAX;
`endif

    logic [CW-1:0]        sf_cnt;
    logic signed [TA-1:0] acc [PE];
    logic signed [TA-1:0] sum [PE];
    logic                 last_beat;
    logic                 accept;

    function automatic logic signed [TA-1:0] lane_add(input logic signed [TA-1:0] a,
                                                       input logic signed [TA-1:0] b);
`ifdef MVU_ACC_SAT_EN
        logic signed [TA:0] s;
        s = {a[TA-1], a} + {b[TA-1], b};
        // Disagreement of the two top bits means the true sum left the TA-bit range.
        if (s[TA] != s[TA-1])
            return s[TA] ? SMIN : SMAX;
        return s[TA-1:0];
`else
        return a + b;
`endif
    endfunction

    assign last_beat = (sf_cnt == LAST_CNT);
    assign in_rdy    = !(last_beat && out_v && !out_rdy);
    assign accept    = in_v && in_rdy;

    // The first beat of a fold adds onto zero, dropping the previous vector's sum.
    always_comb begin
        for (int unsigned p = 0; p < PE; p++) begin
            sum[p] = lane_add((sf_cnt == '0) ? '0 : acc[p],
                              TA'(signed'(in_data[p*TO +: TO])));
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sf_cnt   <= '0;
            out_v    <= 1'b0;
            out_data <= '0;
            for (int unsigned p = 0; p < PE; p++)
                acc[p] <= '0;
        end else begin
            if (out_v && out_rdy)
                out_v <= 1'b0;
            if (accept) begin
                if (last_beat) begin
                    sf_cnt <= '0;
                    out_v  <= 1'b1;
                    for (int unsigned p = 0; p < PE; p++)
                        out_data[p*TA +: TA] <= sum[p];
                end else begin
                    sf_cnt <= sf_cnt + 1'b1;
                    for (int unsigned p = 0; p < PE; p++)
                        acc[p] <= sum[p];
                end
            end
        end
    end

endmodule

// File: tb/tb_mvu_pe_acc.sv
// Directed-vector bench for mvu_pe_acc: fold accumulation, back-pressure, reset, overflow and SF=1.
module tb_mvu_pe_acc;

    logic clk = 1'b0;
    logic rst = 1'b1;

    // Config A: PE=2, TO=8, TA=16, SF=4
    logic        a_in_v = 1'b0, a_in_rdy, a_out_v, a_out_rdy = 1'b1;
    logic [15:0] a_in_data = '0;
    logic [31:0] a_out_data;

    // Config B: PE=2, TO=8, TA=9, SF=4 (overflow)
    logic        b_in_v = 1'b0, b_in_rdy, b_out_v, b_out_rdy = 1'b1;
    logic [15:0] b_in_data = '0;
    logic [17:0] b_out_data;

    // Config C: PE=2, TO=8, TA=16, SF=1
    logic        c_in_v = 1'b0, c_in_rdy, c_out_v, c_out_rdy = 1'b1;
    logic [15:0] c_in_data = '0;
    logic [31:0] c_out_data;

    int nvec = 0;
    int nerr = 0;

    mvu_pe_acc #(.PE(2), .TO(8), .TA(16), .SF(4)) u_a (
        .clk(clk), .rst(rst), .in_v(a_in_v), .in_rdy(a_in_rdy), .in_data(a_in_data),
        .out_v(a_out_v), .out_rdy(a_out_rdy), .out_data(a_out_data));

    mvu_pe_acc #(.PE(2), .TO(8), .TA(9), .SF(4)) u_b (
        .clk(clk), .rst(rst), .in_v(b_in_v), .in_rdy(b_in_rdy), .in_data(b_in_data),
        .out_v(b_out_v), .out_rdy(b_out_rdy), .out_data(b_out_data));

    mvu_pe_acc #(.PE(2), .TO(8), .TA(16), .SF(1)) u_c (
        .clk(clk), .rst(rst), .in_v(c_in_v), .in_rdy(c_in_rdy), .in_data(c_in_data),
        .out_v(c_out_v), .out_rdy(c_out_rdy), .out_data(c_out_data));

    always #5 clk = ~clk;

    task automatic check(input string tag, input int got, input int exp);
        nvec++;
        if (got !== exp) begin
            nerr++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic int a_lane(input int p);
        logic [15:0] v;
        v = a_out_data[p*16 +: 16];
        return int'($signed(v));
    endfunction

    function automatic int b_lane(input int p);
        logic [8:0] v;
        v = b_out_data[p*9 +: 9];
        return int'($signed(v));
    endfunction

    function automatic int c_lane(input int p);
        logic [15:0] v;
        v = c_out_data[p*16 +: 16];
        return int'($signed(v));
    endfunction

    task automatic a_beat(input int l0, input int l1);
        a_in_v    = 1'b1;
        a_in_data = {8'(l1), 8'(l0)};
    endtask

    task automatic check_a(input string tag, input int v, input int l0, input int l1);
        check({tag, ".v"},  int'(a_out_v), v);
        check({tag, ".l0"}, a_lane(0), l0);
        check({tag, ".l1"}, a_lane(1), l1);
    endtask

    initial begin
        // reset state
        #12;
        check("rst.a_out_v",   int'(a_out_v), 0);
        check("rst.a_out_data", int'(a_out_data), 0);
        check("rst.a_in_rdy",  int'(a_in_rdy), 1);
        check("rst.c_out_v",   int'(c_out_v), 0);
        rst = 1'b0;
        tick();

        // basic fold: (1,-1)..(4,-4) -> (10,-10)
        for (int k = 1; k <= 4; k++) begin
            a_beat(k, -k);
            check($sformatf("t1.rdy%0d", k), int'(a_in_rdy), 1);
            tick();
            if (k < 4) check($sformatf("t1.v%0d", k), int'(a_out_v), 0);
        end
        a_in_v = 1'b0;
        check_a("t1.res", 1, 10, -10);
        tick();
        check("t1.clr", int'(a_out_v), 0);

        // continuous stream: 12 beats of (1,1)
        a_beat(1, 1);
        for (int k = 1; k <= 12; k++) begin
            check($sformatf("t2.rdy%0d", k), int'(a_in_rdy), 1);
            tick();
            check($sformatf("t2.v%0d", k), int'(a_out_v), (k % 4 == 0) ? 1 : 0);
            if (k % 4 == 0) begin
                check($sformatf("t2.l0_%0d", k), a_lane(0), 4);
                check($sformatf("t2.l1_%0d", k), a_lane(1), 4);
            end
        end
        a_in_v = 1'b0;
        tick();
        check("t2.clr", int'(a_out_v), 0);

        // back-pressure: first result (10,-10), then (5,5)x4 with out_rdy=0
        for (int k = 1; k <= 4; k++) begin
            a_beat(k, -k);
            tick();
        end
        check_a("t3.first", 1, 10, -10);
        a_out_rdy = 1'b0;
        a_beat(5, 5);
        for (int k = 1; k <= 3; k++) begin
            check($sformatf("t3.rdy%0d", k), int'(a_in_rdy), 1);
            tick();
        end
        check("t3.stall", int'(a_in_rdy), 0);
        tick();
        check_a("t3.hold", 1, 10, -10);
        check("t3.stall2", int'(a_in_rdy), 0);
        a_out_rdy = 1'b1;
        #1;
        check("t3.release", int'(a_in_rdy), 1);
        tick();
        check_a("t3.second", 1, 20, 20);

        // reset mid-fold while a result is held
        a_out_rdy = 1'b0;
        a_beat(7, 7);
        tick();
        tick();
        a_in_v = 1'b0;
        check_a("t4.pre", 1, 20, 20);
        #2 rst = 1'b1;
        #1;
        check("t4.v_async", int'(a_out_v), 0);
        check("t4.d_async", int'(a_out_data), 0);
        #1 rst = 1'b0;
        a_out_rdy = 1'b1;
        tick();
        for (int k = 1; k <= 4; k++) begin
            a_beat(1, 2);
            tick();
        end
        a_in_v = 1'b0;
        check_a("t4.res", 1, 4, 8);
        tick();

        // overflow: (127,-128)x4 at TA=9
        b_in_v    = 1'b1;
        b_in_data = {8'h80, 8'h7f};
        for (int k = 1; k <= 4; k++) tick();
        b_in_v = 1'b0;
        check("t5.v", int'(b_out_v), 1);
`ifdef MVU_ACC_SAT_EN
        check("t5.l0", b_lane(0), 255);
        check("t5.l1", b_lane(1), -256);
`else
        check("t5.l0", b_lane(0), -4);
        check("t5.l1", b_lane(1), 0);
`endif
        tick();

        // SF=1: every beat is final, sign-extended
        c_in_v    = 1'b1;
        c_in_data = {8'(100), 8'(-3)};
        tick();
        check("t6.v1", int'(c_out_v), 1);
        check("t6.a0", c_lane(0), -3);
        check("t6.a1", c_lane(1), 100);
        c_in_data = {8'(-7), 8'(5)};
        tick();
        c_in_v = 1'b0;
        check("t6.v2", int'(c_out_v), 1);
        check("t6.b0", c_lane(0), 5);
        check("t6.b1", c_lane(1), -7);
        tick();
        check("t6.clr", int'(c_out_v), 0);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
